// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : usr_pkg
// Description : Shared opcode and FSM-state types for the parametrised
//               universal shift register, plus a helper that classifies
//               opcodes as multi-step (shift/rotate) or single-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_SHL   = 3'd1,
    OP_SHR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } usr_op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_e;

  // Shift and rotate opcodes honour the shift count; every other opcode
  // completes at the edge that accepts it.
  function automatic logic is_multi_step(input usr_op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : usr_shift_step
// Description : Combinational next-state of the data register for one step
//               of the selected operation.
// Ports       : op          - operation to apply
//               r           - current register contents
//               ser_l       - MSB fill for SHR
//               ser_r       - LSB fill for SHL
//               parallel_in - LOAD data
//               next_r      - register contents after one step
// Revision    : 1.0 - initial release
// ============================================================================
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  usr_op_e               op,
  input  logic [DATA_WIDTH-1:0] r,
  input  logic                  ser_l,
  input  logic                  ser_r,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  output logic [DATA_WIDTH-1:0] next_r
);

  always_comb begin
    next_r = r;
    case (op)
      OP_NOP:   next_r = r;
      OP_SHL:   next_r = {r[DATA_WIDTH-2:0], ser_r};
      OP_SHR:   next_r = {ser_l, r[DATA_WIDTH-1:1]};
      OP_LOAD:  next_r = parallel_in;
      OP_ROL:   next_r = {r[DATA_WIDTH-2:0], r[DATA_WIDTH-1]};
      OP_ROR:   next_r = {r[0], r[DATA_WIDTH-1:1]};
      OP_ASR:   next_r = {r[DATA_WIDTH-1], r[DATA_WIDTH-1:1]};
      OP_CLEAR: next_r = '0;
      default:  next_r = r;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/universal_shift_register_param.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register_param
// Description : Parametrised universal shift register with shift, rotate,
//               arithmetic-shift, load and clear. Shift/rotate commands run
//               for Shift_Count_In single-bit steps, one step per enabled
//               clock, under a valid/ready handshake with busy/done status.
// Ports       : Clk_In, Reset_In (sync, active-low), Enable_In (0 freezes
//               all state and floats the data outputs), Cmd_Valid_In /
//               Cmd_Ready_Out handshake, USR_Operation_Select_In opcode,
//               Shift_Count_In step count, serial fills/outputs at both
//               ends, Parallel_Data_In / Parallel_Data_Out, Busy_Out and
//               a one-cycle Done_Out pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register_param
  import usr_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic                   Cmd_Valid_In,
  output logic                   Cmd_Ready_Out,
  input  logic [2:0]             USR_Operation_Select_In,
  input  logic [COUNT_WIDTH-1:0] Shift_Count_In,
  input  logic                   Serial_Left_Side_Data_In,
  input  logic                   Serial_Right_Side_Data_In,
  output logic                   Serial_Left_Side_Data_Out,
  output logic                   Serial_Right_Side_Data_Out,
  input  logic [DATA_WIDTH-1:0]  Parallel_Data_In,
  output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
  output logic                   Busy_Out,
  output logic                   Done_Out
);

  localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

  usr_state_e             r_state;
  usr_op_e                r_op;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_done;

  usr_op_e                w_cmd_op;
  usr_op_e                w_step_op;
  logic [DATA_WIDTH-1:0]  w_next;
  logic                   w_cmd_multi;

  assign w_cmd_op    = usr_op_e'(USR_Operation_Select_In);
  assign w_cmd_multi = is_multi_step(w_cmd_op);
  // A running multi-step operation uses its latched opcode; otherwise the
  // step logic evaluates the opcode currently presented on the command port.
  assign w_step_op   = (r_state == SHIFT) ? r_op : w_cmd_op;

  usr_shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .op          (w_step_op),
    .r           (r_data),
    .ser_l       (Serial_Left_Side_Data_In),
    .ser_r       (Serial_Right_Side_Data_In),
    .parallel_in (Parallel_Data_In),
    .next_r      (w_next)
  );

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_count <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else if (Enable_In) begin
      r_done <= 1'b0;
      if (r_state == SHIFT) begin
        r_data  <= w_next;
        r_count <= r_count - c_count_one;
        if (r_count == c_count_one) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end else if (Cmd_Valid_In) begin
        if (w_cmd_multi && (Shift_Count_In == '0)) begin
          // Zero-length shift: nothing moves, but the command still completes.
          r_done <= 1'b1;
        end else if (w_cmd_multi && (Shift_Count_In > c_count_one)) begin
          // First step happens at the accepting edge; the rest run in SHIFT.
          r_data  <= w_next;
          r_op    <= w_cmd_op;
          r_count <= Shift_Count_In - c_count_one;
          r_state <= SHIFT;
        end else begin
          r_data <= w_next;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign Cmd_Ready_Out              = Enable_In & (r_state == IDLE);
  assign Busy_Out                   = (r_state == SHIFT);
  assign Done_Out                   = r_done;
  assign Parallel_Data_Out          = Enable_In ? r_data : {DATA_WIDTH{1'bz}};
  assign Serial_Left_Side_Data_Out  = Enable_In ? r_data[DATA_WIDTH-1] : 1'bz;
  assign Serial_Right_Side_Data_Out = Enable_In ? r_data[0] : 1'bz;

endmodule
`default_nettype wire
